p2s_chain_tx: RTL and testbench
===============================

Name: p2s_chain_tx

Overview:
- Parametrised parallel-to-serial transmitter for driving chained external shift registers (74HC164/595-style) behind LED and seven-segment display ports.
- Captures a parallel word and optionally clears the chain. Shifts the word out with a programmable serial-clock rate and bit order, then pulses a latch strobe.
- A one-deep pending buffer lets the next frame be queued while the current frame is shifting. Start/busy/done handshake toward the CPU-side IO logic.

Parameters:
- DATA_BITS, 64, frame length in bits (≥2).
- CNT_BITS, 6, bit-counter width; must satisfy 2^CNT_BITS ≥ DATA_BITS.
- HALF_PERIOD, 1, clk cycles per sclk half-period (H, ≥1).
- HP_BITS, 4, half-period counter width; must satisfy 2^HP_BITS > HALF_PERIOD.
- DIR, 1, 1 = MSB first, 0 = LSB first.
- CLR_FIRST, 1, 1 = assert sclrn low before each frame; 0 = skip clear phase.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on each rising clk edge.
- pdata  in  DATA_BITS  parallel word, captured on an accepted start.
- sclk  out  1  serial clock to the chain; data is shifted on its rising edge.
- sclrn  out  1  active-low chain clear.
- sout  out  1  serial data.
- slatch  out  1  output-latch strobe, active high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at the end of each frame.
- pend  out  1  pending buffer holds a queued frame.
- overrun  out  1  one-cycle pulse when a start is dropped.

Behaviour:
- Reset (async, any state, mid-frame included):
  - State goes to IDLE.
  - sclk=0, sclrn=1, sout=0, slatch=0, busy=0, done=0, pend=0, overrun=0.
  - Shift, pending and counter registers are cleared.
  - No partial frame resumes after reset.
- All outputs are registered.
- States: IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE:
  - start=1 loads pdata into the shift register and the bit counter to 0.
  - Next state is CLEAR if CLR_FIRST=1, else SHIFT_LO.
  - busy=1 from the following cycle.
- CLEAR: sclrn=0, sclk=0 for 2H cycles, then SHIFT_LO.
- SHIFT_LO:
  - On entry, sout = current bit: shift[DATA_BITS-1] if DIR=1, shift[0] if DIR=0.
  - sclk=0 for H cycles, then SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for H cycles. sout stays stable across the rising edge.
  - On exit, shift by one toward the output end, zero-fill, and increment the bit counter.
  - If the counter reaches DATA_BITS-1 before the increment, go to LATCH; else go to SHIFT_LO.
- LATCH: sclk=0, slatch=1 for H cycles; sout holds the last bit. Then DONE.
- DONE:
  - done=1 for exactly one cycle; busy stays 1.
  - If pend=1: load the pending word, clear pend, and go to CLEAR/SHIFT_LO with no IDLE gap.
  - Otherwise go to IDLE; busy=0 and sout=0 from the next cycle.
- Frame length from the accepting edge to the IDLE return: 2H·CLR_FIRST + 2H·DATA_BITS + H + 1 cycles.
- start while busy=1:
  - If pend=0, capture pdata into the pending buffer and set pend=1.
  - If pend=1, drop the word, keep the existing pending word, and pulse overrun=1 for one cycle.
- start in the DONE cycle with pend=0 is queued as pending. That frame then starts immediately, equivalent to back-to-back operation.
- A held start re-triggers each frame; the source must deassert start after acceptance.
- pdata changes after capture have no effect on the frame in flight.
- Counters wrap only via explicit reload; no free-running counters.

Test Plan:
1. DATA_BITS=8, H=1, DIR=1, CLR_FIRST=1, start one cycle with pdata=0xC1:
   - sclrn low for 2 cycles.
   - sout values at the 8 sclk rising edges are 1,1,0,0,0,0,0,1.
   - slatch high for 1 cycle.
   - done pulses 20 cycles after the accepting edge; busy falls on the next cycle.
2. Same configuration with DIR=0, pdata=0xC1:
   - sout sequence is 1,0,0,0,0,0,1,1.
   - CLR_FIRST=0 shortens the frame to 18 cycles with sclrn held at 1.
3. H=3, DATA_BITS=8, pdata=0xFF:
   - sclk high and low phases are exactly 3 cycles each.
   - done pulses at cycle 2·3 + 48 + 3 + 1 = 58.
4. Queueing: pdata=0x12 accepted, then start with 0x34 mid-frame, then start with 0x56 mid-frame:
   - pend=1 after 0x34.
   - overrun pulses once on the 0x56 start.
   - Frame 0x34 follows frame 0x12 with no IDLE cycle.
   - 0x56 is never transmitted.
5. Reset mid-frame: assert rst during SHIFT_HI of bit 4:
   - All outputs reach their reset values asynchronously (before the next clk edge).
   - After release, a new start with 0xA0 transmits cleanly from bit 0.
6. DATA_BITS=64 default, pdata=0x8000_0000_0000_0001, DIR=1:
   - The first and last shifted bits are 1; all 62 middle bits are 0.
   - Exactly 64 sclk rising edges occur per frame.

Source files
------------

// File: rtl/p2s_chain_tx.sv
// Parallel-to-serial transmitter for chained 74HC164/595-style shift registers.
// Clear, shift with programmable sclk rate and bit order, latch; one-deep pending queue.
module p2s_chain_tx #(
   parameter int unsigned DATA_BITS   = 64,
   parameter int unsigned CNT_BITS    = 6,
   parameter int unsigned HALF_PERIOD = 1,
   parameter int unsigned HP_BITS     = 4,
   parameter int unsigned DIR         = 1,
   parameter int unsigned CLR_FIRST   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] pdata,
   output logic                 sclk,
   output logic                 sclrn,
   output logic                 sout,
   output logic                 slatch,
   output logic                 busy,
   output logic                 done,
   output logic                 pend,
   output logic                 overrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_DONE
   } state_t;

   localparam logic [HP_BITS-1:0]  HP_LAST  = HP_BITS'(HALF_PERIOD - 1);
   localparam logic [CNT_BITS-1:0] BIT_LAST = CNT_BITS'(DATA_BITS - 1);
   localparam state_t             S_FIRST  = (CLR_FIRST != 0) ? S_CLEAR : S_SHIFT_LO;

   state_t               r_state;
   state_t               w_next;
   logic [HP_BITS-1:0]   r_hp;
   logic                 r_clr_ph;
   logic [CNT_BITS-1:0]  r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_pend_data;
   logic                 r_pend;
   logic                 r_sclk, r_sclrn, r_sout, r_slatch, r_busy, r_done, r_overrun;

   logic                 w_hp_end, w_timed, w_load, w_step;
   logic                 w_pend_take, w_pend_set, w_overrun;
   logic [DATA_BITS-1:0] w_shifted, w_shift_nx;
   logic                 w_out_bit;
   logic                 w_sclk, w_sclrn, w_sout, w_slatch, w_busy, w_done;

   assign w_hp_end = (r_hp == HP_LAST);
   assign w_timed  = (r_state == S_CLEAR) || (r_state == S_SHIFT_LO) ||
                     (r_state == S_SHIFT_HI) || (r_state == S_LATCH);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; a DONE with work waiting re-enters the frame without an IDLE gap
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next = S_FIRST;
         S_CLEAR:    if (w_hp_end && r_clr_ph) w_next = S_SHIFT_LO;
         S_SHIFT_LO: if (w_hp_end) w_next = S_SHIFT_HI;
         S_SHIFT_HI: if (w_hp_end) w_next = (r_bit == BIT_LAST) ? S_LATCH : S_SHIFT_LO;
         S_LATCH:    if (w_hp_end) w_next = S_DONE;
         S_DONE:     w_next = (r_pend || start) ? S_FIRST : S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Datapath control
   assign w_load      = ((r_state == S_IDLE) && start) ||
                        ((r_state == S_DONE) && (r_pend || start));
   assign w_step      = (r_state == S_SHIFT_HI) && w_hp_end;
   assign w_pend_take = (r_state == S_DONE) && r_pend;
   assign w_pend_set  = start && (r_state != S_IDLE) && (r_state != S_DONE) && !r_pend;
   assign w_overrun   = start && (r_state != S_IDLE) && r_pend;
   assign w_shifted   = (DIR != 0) ? {r_shift[DATA_BITS-2:0], 1'b0}
                                   : {1'b0, r_shift[DATA_BITS-1:1]};
   assign w_shift_nx  = w_load ? (w_pend_take ? r_pend_data : pdata)
                               : (w_step ? w_shifted : r_shift);
   assign w_out_bit   = (DIR != 0) ? w_shift_nx[DATA_BITS-1] : w_shift_nx[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hp        <= '0;
         r_clr_ph    <= 1'b0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_pend_data <= '0;
         r_pend      <= 1'b0;
      end else begin
         if (!w_timed || (w_next != r_state) || w_hp_end) r_hp <= '0;
         else                                             r_hp <= r_hp + HP_BITS'(1);
         if (r_state != S_CLEAR) r_clr_ph <= 1'b0;
         else if (w_hp_end)      r_clr_ph <= 1'b1;
         if (w_load)      r_bit <= '0;
         else if (w_step) r_bit <= r_bit + CNT_BITS'(1);
         r_shift <= w_shift_nx;
         if (w_pend_set) r_pend_data <= pdata;
         if (w_pend_take)     r_pend <= 1'b0;
         else if (w_pend_set) r_pend <= 1'b1;
      end
   end

   // Output decode from next state; sout only changes on entry to SHIFT_LO
   always_comb begin
      w_sclk   = (w_next == S_SHIFT_HI);
      w_sclrn  = (w_next != S_CLEAR);
      w_slatch = (w_next == S_LATCH);
      w_busy   = (w_next != S_IDLE);
      w_done   = (w_next == S_DONE);
      w_sout   = r_sout;
      if (w_next == S_IDLE)
         w_sout = 1'b0;
      else if ((w_next == S_SHIFT_LO) && (r_state != S_SHIFT_LO))
         w_sout = w_out_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk    <= 1'b0;
         r_sclrn   <= 1'b1;
         r_sout    <= 1'b0;
         r_slatch  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_sclk    <= w_sclk;
         r_sclrn   <= w_sclrn;
         r_sout    <= w_sout;
         r_slatch  <= w_slatch;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_overrun <= w_overrun;
      end
   end

   assign sclk    = r_sclk;
   assign sclrn   = r_sclrn;
   assign sout    = r_sout;
   assign slatch  = r_slatch;
   assign busy    = r_busy;
   assign done    = r_done;
   assign pend    = r_pend;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_p2s_chain_tx.sv
// Scoreboard bench for p2s_chain_tx: four configurations, directed frames, a monitor
// reconstructs each shifted frame and its timing and compares against queued expectations.
module tb_p2s_chain_tx;

   typedef struct {
      int          id;
      logic [63:0] seq;
      int          nbits;
      int          lat;
      int          clr;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  st;
   logic [63:0] pd [4];
   logic [3:0]  sclk_o, sclrn_o, sout_o, slatch_o, busy_o, done_o, pend_o, overrun_o;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   int          hp_of [4] = '{1, 1, 3, 1};
   logic        ps  [4];
   logic        pso [4];
   logic        pdn [4];
   logic [63:0] seq [4];
   int nb [4], lat [4], clr [4], cyc [4], hi [4], lo [4], ovr [4];

   always #5 clk = ~clk;

   // u0: 8b H1 MSB-first clear; u1: 8b H1 LSB-first no clear; u2: 8b H3; u3: defaults
   p2s_chain_tx #(.DATA_BITS(8), .CNT_BITS(3), .HALF_PERIOD(1), .HP_BITS(4), .DIR(1), .CLR_FIRST(1)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .pdata(pd[0][7:0]),
      .sclk(sclk_o[0]), .sclrn(sclrn_o[0]), .sout(sout_o[0]), .slatch(slatch_o[0]),
      .busy(busy_o[0]), .done(done_o[0]), .pend(pend_o[0]), .overrun(overrun_o[0]));
   p2s_chain_tx #(.DATA_BITS(8), .CNT_BITS(3), .HALF_PERIOD(1), .HP_BITS(4), .DIR(0), .CLR_FIRST(0)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .pdata(pd[1][7:0]),
      .sclk(sclk_o[1]), .sclrn(sclrn_o[1]), .sout(sout_o[1]), .slatch(slatch_o[1]),
      .busy(busy_o[1]), .done(done_o[1]), .pend(pend_o[1]), .overrun(overrun_o[1]));
   p2s_chain_tx #(.DATA_BITS(8), .CNT_BITS(3), .HALF_PERIOD(3), .HP_BITS(4), .DIR(1), .CLR_FIRST(1)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .pdata(pd[2][7:0]),
      .sclk(sclk_o[2]), .sclrn(sclrn_o[2]), .sout(sout_o[2]), .slatch(slatch_o[2]),
      .busy(busy_o[2]), .done(done_o[2]), .pend(pend_o[2]), .overrun(overrun_o[2]));
   p2s_chain_tx u3 (
      .clk(clk), .rst(rst), .start(st[3]), .pdata(pd[3]),
      .sclk(sclk_o[3]), .sclrn(sclrn_o[3]), .sout(sout_o[3]), .slatch(slatch_o[3]),
      .busy(busy_o[3]), .done(done_o[3]), .pend(pend_o[3]), .overrun(overrun_o[3]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [63:0] out_vec(input int i);
      return 64'({sclk_o[i], sclrn_o[i], sout_o[i], slatch_o[i],
                  busy_o[i], done_o[i], pend_o[i], overrun_o[i]});
   endfunction

   // Monitor: rebuild each frame from sclk rising edges, check phase widths and frame stats
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            ps[i] = 1'b0; pso[i] = 1'b0; pdn[i] = 1'b0; seq[i] = '0;
            nb[i] = 0; lat[i] = 0; clr[i] = 0; cyc[i] = 0; hi[i] = 0; lo[i] = 0; ovr[i] = 0;
         end else begin
            if (pdn[i]) begin
               chk("busy_after_done", 64'(busy_o[i]), 64'(q.size() > 0 && q[0].id == i));
               pdn[i] = 1'b0;
            end
            if (sclk_o[i] && !ps[i]) begin
               if (nb[i] > 0) chk("sclk_low_width", 64'(lo[i]), 64'(hp_of[i]));
               chk("sout_stable_at_rise", 64'(sout_o[i]), 64'(pso[i]));
               seq[i] = {seq[i][62:0], sout_o[i]};
               nb[i]++;
               hi[i] = 1;
            end else if (sclk_o[i]) begin
               hi[i]++;
            end else if (ps[i]) begin
               chk("sclk_high_width", 64'(hi[i]), 64'(hp_of[i]));
               lo[i] = 1;
            end else begin
               lo[i]++;
            end
            if (slatch_o[i]) lat[i]++;
            if (!sclrn_o[i]) clr[i]++;
            if (busy_o[i])   cyc[i]++;
            if (overrun_o[i]) ovr[i]++;
            if (done_o[i]) begin
               if (q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_frame inst %0d: got %0h expected none", i, seq[i]);
               end else begin
                  exp_t e;
                  logic [63:0] m;
                  e = q.pop_front();
                  m = (e.nbits >= 64) ? '1 : ((64'd1 << e.nbits) - 64'd1);
                  chk("frame_inst", 64'(i), 64'(e.id));
                  chk("frame_bits", seq[i] & m, e.seq & m);
                  chk("sclk_rises", 64'(nb[i]), 64'(e.nbits));
                  chk("latch_cycles", 64'(lat[i]), 64'(e.lat));
                  chk("clear_cycles", 64'(clr[i]), 64'(e.clr));
                  chk("frame_cycles", 64'(cyc[i]), 64'(e.cyc));
               end
               seq[i] = '0; nb[i] = 0; lat[i] = 0; clr[i] = 0; cyc[i] = 0;
               pdn[i] = 1'b1;
            end
            pso[i] = sout_o[i];
            ps[i]  = sclk_o[i];
         end
      end
   end

   // One-cycle start pulse; pdata is scrambled right after so late changes are exercised
   task automatic send(input int id, input logic [63:0] d, input logic push,
                       input logic [63:0] s, input int nbits, input int l, input int c, input int cy);
      exp_t e;
      @(negedge clk);
      st[id] = 1'b1;
      pd[id] = d;
      if (push) begin
         e.id = id; e.seq = s; e.nbits = nbits; e.lat = l; e.clr = c; e.cyc = cy;
         q.push_back(e);
      end
      @(negedge clk);
      st[id] = 1'b0;
      pd[id] = {$urandom, $urandom};
   endtask

   task automatic wait_idle(input int id);
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!busy_o[id]) break;
      end
      if (k >= 400) begin
         n_vec++; n_err++;
         $display("FAIL idle_timeout inst %0d: got busy after %0d cycles expected idle", id, k);
      end
   endtask

   initial begin
      int   rises;
      logic p;
      rst = 1'b1;
      st  = '0;
      for (int i = 0; i < 4; i++) pd[i] = '0;
      #1;
      for (int i = 0; i < 4; i++) chk("reset_state", out_vec(i), 64'h40);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // MSB first with clear phase
      send(0, 64'hC1, 1'b1, 64'hC1, 8, 1, 2, 20);
      wait_idle(0);
      // LSB first, no clear phase
      send(1, 64'hC1, 1'b1, 64'h83, 8, 1, 0, 18);
      wait_idle(1);
      send(1, 64'h35, 1'b1, 64'hAC, 8, 1, 0, 18);
      wait_idle(1);
      // Slow sclk, H=3
      send(2, 64'hFF, 1'b1, 64'hFF, 8, 3, 6, 58);
      wait_idle(2);

      // Queueing: 0x34 pends, 0x56 dropped with overrun
      send(0, 64'h12, 1'b1, 64'h12, 8, 1, 2, 20);
      repeat (3) @(negedge clk);
      send(0, 64'h34, 1'b1, 64'h34, 8, 1, 2, 20);
      chk("pend_set", 64'(pend_o[0]), 64'h1);
      send(0, 64'h56, 1'b0, 64'h0, 8, 1, 2, 20);
      wait_idle(0);
      chk("overrun_count", 64'(ovr[0]), 64'h1);
      chk("pend_cleared", 64'(pend_o[0]), 64'h0);

      // Reset during SHIFT_HI of bit 4, with a word pending
      send(0, 64'h3C, 1'b1, 64'h3C, 8, 1, 2, 20);
      send(0, 64'h77, 1'b0, 64'h0, 8, 1, 2, 20);
      rises = 0;
      p = 1'b0;
      for (int k = 0; k < 100 && rises < 5; k++) begin
         @(negedge clk);
         if (sclk_o[0] && !p) rises++;
         p = sclk_o[0];
      end
      chk("reached_bit4", 64'(rises), 64'd5);
      #1 rst = 1'b1;
      #1 chk("async_reset_outputs", out_vec(0), 64'h40);
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send(0, 64'hA0, 1'b1, 64'hA0, 8, 1, 2, 20);
      wait_idle(0);

      // 64-bit default configuration
      send(3, 64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001, 64, 1, 2, 132);
      wait_idle(3);
      send(3, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF, 64, 1, 2, 132);
      wait_idle(3);

      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
